sipo_capture_register: RTL and testbench
========================================

// Module: sipo_capture_register
// PURPOSE
//  Serial-in/parallel-out capture stage downstream of the PIPO/PISO register.
//  Samples bitIn once per divided-clock tick, assembles WIDTH bits LSB first,
//  and presents the word on regOut with a one-cycle valid strobe. It shares the
//  free-running tick divider style so it can phase-lock to the upstream shifter.
// PARAMETERS
//  WIDTH  8          word width in bits, >=2
//  DIV    100000000  clkIn cycles per sample tick, >=2 (sim: 4)
// PORTS
//  clkIn      in   1      system clock; all state on rising edge
//  rstN       in   1      asynchronous, active-low reset
//  bitIn      in   1      serial data from upstream bitOut
//  start      in   1      arm capture; level-sampled, accepted only in IDLE
//  regOut     out  WIDTH  last completed word; holds until next completion
//  valid      out  1      1-cycle pulse: regOut just updated
//  busy       out  1      high in ARMED or SHIFT
//  tickOut    out  1      divided clock; toggles on every tick
//  overrun    out  1      sticky: start seen while busy
//  parityErr  out  1      parity mismatch on last word (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rstN=0, async): state=IDLE, counter=0, shift reg=0, regOut=0, valid=0,
//   busy=0, tickOut=0, overrun=0, parityErr=0. Reset mid-capture discards the
//   partial word; no valid pulse is generated.
//  Divider: counter runs 0..DIV-1 free-running; tick=1 for the cycle counter==DIV-1,
//   then counter wraps to 0; tickOut toggles on the same edge.
//  Accepted start in IDLE forces counter to 0 (phase realign); first tick comes
//   DIV cycles after the accept edge.
//  FSM:
//   IDLE  : start=1 -> ARMED, bitCnt=0.
//   ARMED : immediate transition -> SHIFT on next edge (busy already high).
//   SHIFT : on each tick, shreg <= {bitIn, shreg[WIDTH-1:1]}, bitCnt++.
//           On the tick taking sample N (N=WIDTH, or WIDTH+1 with parity):
//           regOut <= assembled word on that edge, valid=1 for the following
//           cycle only, state -> IDLE, busy=0 in the same cycle valid=1.
//  First received bit lands in regOut[0]; last in regOut[WIDTH-1].
//  start while busy: ignored for capture, overrun <= 1 (cleared only by reset).
//  start held high across completion: re-accepted in the IDLE cycle -> back-to-back
//   capture; overrun not set by the hold in that IDLE cycle.
//  start and a tick in the same IDLE cycle: accept wins, counter cleared, tick
//   still toggles tickOut.
// CONFIGURATION
//  SIPO_PARITY_EN defined: one extra tick samples an even-parity bit after the
//   data bits; parityErr <= ^{word,parityBit} on the completion edge, held
//   until next completion; total samples = WIDTH+1.
//  Not defined: WIDTH samples only; parityErr tied 0.
// TESTING (WIDTH=8, DIV=4)
//  Reset mid-SHIFT after 3 ticks -> all outputs 0 immediately, no valid pulse.
//  start, bitIn drives 0xA5 LSB-first one bit per tick -> regOut=0xA5, valid high
//   exactly 1 cycle, 32 clkIn cycles after accept edge.
//  tickOut toggles every 4 cycles from reset; counter clears on start accept.
//  start pulsed again during SHIFT -> word unaffected, overrun=1 and stays 1.
//  start held high, bitIn streams 0x3C then 0xC3 -> two valid pulses, regOut 0x3C
//   then 0xC3, no overrun.
//  SIPO_PARITY_EN: 0x07 with parity 1 -> parityErr=0; parity 0 -> parityErr=1.

Source files
------------

// File: rtl/sipo_capture_register.sv
// Serial-in/parallel-out capture stage: samples bitIn once per divided tick, LSB first.
// Optional even-parity sample after the data bits when SIPO_PARITY_EN is defined.
module sipo_capture_register #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 100000000
) (
   input  logic             clkIn,
   input  logic             rstN,
   input  logic             bitIn,
   input  logic             start,
   output logic [WIDTH-1:0] regOut,
   output logic             valid,
   output logic             busy,
   output logic             tickOut,
   output logic             overrun,
   output logic             parityErr
);

`ifdef SIPO_PARITY_EN
   localparam int unsigned NSAMP = WIDTH + 1;
`else
   localparam int unsigned NSAMP = WIDTH;
`endif
   localparam int unsigned CNT_W = $clog2(DIV);
   localparam int unsigned BC_W  = $clog2(NSAMP + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [NSAMP-1:0]   shreg_q, shreg_d;
   logic [WIDTH-1:0]   reg_out_q, reg_out_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               tick_out_q, tick_out_d;
   logic               overrun_q, overrun_d;
   logic               start_prev_q;
`ifdef SIPO_PARITY_EN
   logic               par_err_q, par_err_d;
`endif

   logic               tick_c;
   logic [NSAMP-1:0]   shifted_c;

   // Divider, capture FSM and output updates
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      reg_out_d  = reg_out_q;
      valid_d    = 1'b0;
      tick_out_d = tick_out_q;
      overrun_d  = overrun_q;
`ifdef SIPO_PARITY_EN
      par_err_d  = par_err_q;
`endif
      tick_c    = (cnt_q == CNT_W'(DIV - 1));
      shifted_c = {bitIn, shreg_q[NSAMP-1:1]};

      cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
      if (tick_c) begin
         tick_out_d = ~tick_out_q;
      end

      // Only a fresh assertion counts as overrun, so a start held from accept is benign
      if (start && !start_prev_q && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_ARMED;
               bit_cnt_d = '0;
               cnt_d     = '0;
               shreg_d   = '0;
            end
         end
         ST_ARMED: begin
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (tick_c) begin
               shreg_d   = shifted_c;
               bit_cnt_d = bit_cnt_q + BC_W'(1);
               if (bit_cnt_q == BC_W'(NSAMP - 1)) begin
                  reg_out_d = shifted_c[WIDTH-1:0];
                  valid_d   = 1'b1;
                  state_d   = ST_IDLE;
`ifdef SIPO_PARITY_EN
                  par_err_d = ^shifted_c;
`endif
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clkIn or negedge rstN) begin
      if (!rstN) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         reg_out_q    <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         tick_out_q   <= 1'b0;
         overrun_q    <= 1'b0;
         start_prev_q <= 1'b0;
`ifdef SIPO_PARITY_EN
         par_err_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         reg_out_q    <= reg_out_d;
         valid_q      <= valid_d;
         busy_q       <= busy_d;
         tick_out_q   <= tick_out_d;
         overrun_q    <= overrun_d;
         start_prev_q <= start;
`ifdef SIPO_PARITY_EN
         par_err_q    <= par_err_d;
`endif
      end
   end

   assign regOut  = reg_out_q;
   assign valid   = valid_q;
   assign busy    = busy_q;
   assign tickOut = tick_out_q;
   assign overrun = overrun_q;
`ifdef SIPO_PARITY_EN
   assign parityErr = par_err_q;
`else
   assign parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_capture_register.sv
// Bench for sipo_capture_register (WIDTH=8, DIV=4): randomized serial words against a
// timing/word model derived from tick arithmetic; honours SIPO_PARITY_EN if defined.
module tb_sipo_capture_register;
   localparam int WIDTH = 8;
   localparam int DIV   = 4;
`ifdef SIPO_PARITY_EN
   localparam int NS = WIDTH + 1;
`else
   localparam int NS = WIDTH;
`endif

   logic             clkIn = 1'b0;
   logic             rstN;
   logic             bitIn;
   logic             start;
   logic [WIDTH-1:0] regOut;
   logic             valid;
   logic             busy;
   logic             tickOut;
   logic             overrun;
   logic             parityErr;

   sipo_capture_register #(.WIDTH(WIDTH), .DIV(DIV)) dut (
      .clkIn     (clkIn),
      .rstN      (rstN),
      .bitIn     (bitIn),
      .start     (start),
      .regOut    (regOut),
      .valid     (valid),
      .busy      (busy),
      .tickOut   (tickOut),
      .overrun   (overrun),
      .parityErr (parityErr)
   );

   always #5 clkIn = ~clkIn;

   int               n_cmp = 0;
   int               n_err = 0;
   int               cyc = 0;
   int               align_edge = 0;
   int               tick_base = 0;
   logic [WIDTH-1:0] exp_reg = '0;
   bit               exp_ovr = 1'b0;
   bit               exp_perr = 1'b0;

   // Edges counted since reset release; the divider phase restarts at align_edge
   function automatic int ticks_at(input int e);
      return tick_base + (e - align_edge) / DIV;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clkIn);
         cyc++;
      end
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input bit ev, input bit eb);
      chk({tag, ".valid"},     32'(valid),     32'(ev));
      chk({tag, ".busy"},      32'(busy),      32'(eb));
      chk({tag, ".regOut"},    32'(regOut),    32'(exp_reg));
      chk({tag, ".tickOut"},   32'(tickOut),   32'(ticks_at(cyc) % 2));
      chk({tag, ".overrun"},   32'(overrun),   32'(exp_ovr));
      chk({tag, ".parityErr"}, 32'(parityErr), 32'(exp_perr));
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) begin
         start = 1'b0;
         bitIn = 1'($urandom);
         step(1);
         chk_all("idle", 1'b0, 1'b0);
      end
   endtask

   task automatic realign();
      tick_base  = ticks_at(cyc);
      align_edge = cyc;
   endtask

   // One full capture; ovr_k >= 0 pulses start during sample period ovr_k
   task automatic capture(input logic [WIDTH-1:0] word, input bit par,
                          input bit keep_start, input int ovr_k);
      logic [NS-1:0] bits;
      bits  = NS'({par, word});
      start = 1'b1;
      step(1);
      realign();
      if (!keep_start) start = 1'b0;
      chk_all("accept", 1'b0, 1'b1);
      for (int k = 0; k < NS; k++) begin
         for (int j = 0; j < DIV; j++) begin
            bitIn = (j == DIV - 1) ? bits[k] : 1'($urandom);
            if (k == ovr_k && j == 1) start = 1'b1;
            step(1);
            if (k == ovr_k && j == 1) begin
               start   = 1'b0;
               exp_ovr = 1'b1;
            end
            if (k == NS - 1 && j == DIV - 1) begin
               exp_reg = word;
`ifdef SIPO_PARITY_EN
               exp_perr = ^bits;
`endif
               chk_all("done", 1'b1, 1'b0);
            end else begin
               chk_all("shift", 1'b0, 1'b1);
            end
         end
      end
   endtask

   initial begin
      logic [WIDTH-1:0] w;
      rstN  = 1'b0;
      start = 1'b0;
      bitIn = 1'b0;
      step(3);
      chk_all("reset", 1'b0, 1'b0);
      rstN       = 1'b1;
      cyc        = 0;
      align_edge = 0;
      tick_base  = 0;

      // Free-running divider from reset
      idle_steps(13);

      // Directed 0xA5 word
      idle_steps(int'($urandom_range(0, 5)));
      capture(8'hA5, 1'b0, 1'b0, -1);
      idle_steps(2);

      // Start pulse mid-capture: word intact, overrun sticky
      idle_steps(int'($urandom_range(0, 5)));
      w = WIDTH'($urandom);
      capture(w, ^w, 1'b0, int'($urandom_range(0, NS - 1)));
      idle_steps(6);

      // Reset after 3 ticks of a capture: everything clears at once, no valid later
      start = 1'b1;
      step(1);
      realign();
      start = 1'b0;
      for (int i = 0; i < 3 * DIV; i++) begin
         bitIn = 1'($urandom);
         step(1);
         chk_all("pre_rst", 1'b0, 1'b1);
      end
      #2;
      rstN = 1'b0;
      #1;
      exp_reg  = '0;
      exp_ovr  = 1'b0;
      exp_perr = 1'b0;
      tick_base  = 0;
      align_edge = cyc;
      chk_all("mid_rst", 1'b0, 1'b0);
      step(2);
      rstN       = 1'b1;
      cyc        = 0;
      align_edge = 0;
      tick_base  = 0;
      idle_steps(3 * DIV * NS / 2);

      // Start held across completion: back-to-back words, no overrun
      idle_steps(int'($urandom_range(0, 5)));
      capture(8'h3C, 1'b0, 1'b1, -1);
      capture(8'hC3, 1'b0, 1'b0, -1);
      idle_steps(2);

      // Parity-bit handling (parityErr stays 0 when parity is not built in)
      capture(8'h07, 1'b1, 1'b0, -1);
      idle_steps(1);
      capture(8'h07, 1'b0, 1'b0, -1);
      idle_steps(1);

      // Random words, gaps, parity bits and occasional overrun pulses
      for (int n = 0; n < 6; n++) begin
         idle_steps(int'($urandom_range(0, 6)));
         w = WIDTH'($urandom);
         capture(w, 1'($urandom), 1'b0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NS - 1)) : -1);
      end
      idle_steps(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
